// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   IFImemReq    fetch request (fetch unit -> memory)
//   IFImemAddr   fetch address, XLEN bits (fetch unit -> memory)
//   IFImemGnt    memory accepts the request this cycle (memory -> fetch unit)
//   IFImemRValid read data valid (memory -> fetch unit)
//   IFImemRData  32-bit read data (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            IFImemReq;
  logic [XLEN-1:0] IFImemAddr;
  logic            IFImemGnt;
  logic            IFImemRValid;
  logic [31:0]     IFImemRData;

  modport master (
    output IFImemReq, IFImemAddr,
    input  IFImemGnt, IFImemRValid, IFImemRData
  );

  modport slave (
    input  IFImemReq, IFImemAddr,
    output IFImemGnt, IFImemRValid, IFImemRData
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the instruction decoder. Holds the PC, fetches one
// instruction at a time over the req/gnt/rvalid bus, and presents the held
// instruction plus its decoded register/opcode fields until the core retires
// it with IFAdvance. Next PC is PC+4 or the redirect target (bit0 cleared).
//
// Parameters: XLEN (PC width), RESET_PC (PC after reset), TIMEOUT (max
// REQ+WAIT cycles before a bus error, 0 disables).
// Ports:
//   IFClk, IFRstN        clock, synchronous active-low reset
//   imem                 fetch bus (master modport of instr_fetch_unit_if)
//   IFAdvance            core retires the presented instruction
//   IFNextPCSrc/IFTarget redirect select and target, sampled with IFAdvance
//   IFInstValid, IFInst  held instruction and its valid flag
//   IFOpcode..IFRd       instruction fields
//   IFPC, IFPCPlus4      PC of the held/fetching instruction and its link value
//   IFErr, IFMisaligned  sticky fetch error / misaligned-target flags
// Build option: IF_MISALIGN_TRAP_EN -- a taken redirect with target bit1 set
// loads the PC, issues no fetch and enters the error state with IFMisaligned.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic                IFClk,
  input  logic                IFRstN,
  instr_fetch_unit_if.master  imem,
  input  logic                IFAdvance,
  input  logic                IFNextPCSrc,
  input  logic [XLEN-1:0]     IFTarget,
  output logic                IFInstValid,
  output logic [31:0]         IFInst,
  output logic [6:0]          IFOpcode,
  output logic [2:0]          IFFunct3,
  output logic [6:0]          IFFunct7,
  output logic [4:0]          IFRs1,
  output logic [4:0]          IFRs2,
  output logic [4:0]          IFRd,
  output logic [XLEN-1:0]     IFPC,
  output logic [XLEN-1:0]     IFPCPlus4,
  output logic                IFErr,
  output logic                IFMisaligned
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_ERR} state_t;

  // Counter is one wider than TIMEOUT needs so a grant on the expiry cycle
  // can carry the count into WAIT without wrapping.
  localparam int unsigned     CW       = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0]   TO_LIMIT = CW'(TIMEOUT);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     inst_q;
  logic            req_q;
  logic            valid_q;
  logic            err_q;
  logic            mis_q;
  logic [CW-1:0]   tcnt;
  logic [CW-1:0]   tcnt_inc;
  logic            expire;
  logic            trap;

  always_comb begin
    pc_plus4    = pc + XLEN'(4);
    redirect_pc = IFTarget & ~XLEN'(1);
    tcnt_inc    = tcnt + CW'(1);
    expire      = (TIMEOUT != 0) && (tcnt_inc >= TO_LIMIT);
  end

`ifdef IF_MISALIGN_TRAP_EN
  assign trap = IFNextPCSrc & IFTarget[1];
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge IFClk) begin
    if (!IFRstN) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0000_0013;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
          tcnt  <= '0;
        end
        // Grant/rvalid are checked before expiry so they win a tie.
        S_REQ: begin
          if (imem.IFImemGnt) begin
            state <= S_WAIT;
            req_q <= 1'b0;
            tcnt  <= tcnt_inc;
          end else if (expire) begin
            state <= S_ERR;
            req_q <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_WAIT: begin
          if (imem.IFImemRValid) begin
            state   <= S_VALID;
            inst_q  <= imem.IFImemRData;
            valid_q <= 1'b1;
          end else if (expire) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_VALID: begin
          if (IFAdvance) begin
            valid_q <= 1'b0;
            pc      <= IFNextPCSrc ? redirect_pc : pc_plus4;
            if (trap) begin
              state <= S_ERR;
              err_q <= 1'b1;
              mis_q <= 1'b1;
            end else begin
              state <= S_REQ;
              req_q <= 1'b1;
              tcnt  <= '0;
            end
          end
        end
        S_ERR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state   <= S_ERR;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem.IFImemReq  = req_q;
  assign imem.IFImemAddr = pc;

  assign IFInstValid  = valid_q;
  assign IFInst       = inst_q;
  assign IFOpcode     = inst_q[6:0];
  assign IFFunct3     = inst_q[14:12];
  assign IFFunct7     = inst_q[31:25];
  assign IFRs1        = inst_q[19:15];
  assign IFRs2        = inst_q[24:20];
  assign IFRd         = inst_q[11:7];
  assign IFPC         = pc;
  assign IFPCPlus4    = pc_plus4;
  assign IFErr        = err_q;
  assign IFMisaligned = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: decode table, directed corner
// sequences (latency, redirect, wrap, timeout, tie, abort, misalign) and a
// randomized run against a PC/memory reference model.
module tb_instr_fetch_unit;
  localparam int unsigned XLEN = 32;

  logic        IFClk = 1'b0;
  logic        IFRstN;
  logic        IFAdvance;
  logic        IFNextPCSrc;
  logic [31:0] IFTarget;
  logic        IFInstValid;
  logic [31:0] IFInst;
  logic [6:0]  IFOpcode;
  logic [2:0]  IFFunct3;
  logic [6:0]  IFFunct7;
  logic [4:0]  IFRs1;
  logic [4:0]  IFRs2;
  logic [4:0]  IFRd;
  logic [31:0] IFPC;
  logic [31:0] IFPCPlus4;
  logic        IFErr;
  logic        IFMisaligned;

  instr_fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .TIMEOUT(255)) dut (
    .IFClk        (IFClk),
    .IFRstN       (IFRstN),
    .imem         (imem_bus),
    .IFAdvance    (IFAdvance),
    .IFNextPCSrc  (IFNextPCSrc),
    .IFTarget     (IFTarget),
    .IFInstValid  (IFInstValid),
    .IFInst       (IFInst),
    .IFOpcode     (IFOpcode),
    .IFFunct3     (IFFunct3),
    .IFFunct7     (IFFunct7),
    .IFRs1        (IFRs1),
    .IFRs2        (IFRs2),
    .IFRd         (IFRd),
    .IFPC         (IFPC),
    .IFPCPlus4    (IFPCPlus4),
    .IFErr        (IFErr),
    .IFMisaligned (IFMisaligned)
  );

  always #5 IFClk = ~IFClk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge IFClk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_bus.IFImemGnt    = 1'b0;
    imem_bus.IFImemRValid = 1'b0;
    imem_bus.IFImemRData  = 32'h0;
    IFAdvance   = 1'b0;
    IFNextPCSrc = 1'b0;
    IFTarget    = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    IFRstN = 1'b0;
    tick();
    tick();
    IFRstN = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_bus.IFImemReq && n < 16) begin
      tick();
      n++;
    end
    if (!imem_bus.IFImemReq) begin
      checks++;
      errors++;
      $display("FAIL %s_req: got req=0 expected req=1 within 16 cycles", name);
    end
  endtask

  // One fetch with gnt in the first visible REQ cycle and rvalid right after.
  task automatic fetch(input string name, input logic [31:0] exp_addr, input logic [31:0] w);
    wait_req(name);
    chk({name, "_addr"}, imem_bus.IFImemAddr, exp_addr);
    imem_bus.IFImemGnt = 1'b1;
    tick();
    imem_bus.IFImemGnt    = 1'b0;
    imem_bus.IFImemRValid = 1'b1;
    imem_bus.IFImemRData  = w;
    tick();
    imem_bus.IFImemRValid = 1'b0;
    chk({name, "_valid"}, 32'(IFInstValid), 32'd1);
    chk({name, "_inst"}, IFInst, w);
  endtask

  task automatic advance(input logic s, input logic [31:0] t);
    IFAdvance   = 1'b1;
    IFNextPCSrc = s;
    IFTarget    = t;
    tick();
    IFAdvance   = 1'b0;
    IFNextPCSrc = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        granted;
    int          wcnt;
    int          req_age;
    int          presented;
    logic        seen;

    vecs[0] = '{32'h00A3_0333, 7'h33, 3'd0, 7'h00, 5'd6,  5'd6,  5'd10};
    vecs[1] = '{32'hFFFF_FFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31};
    vecs[2] = '{32'h40B5_0533, 7'h33, 3'd0, 7'h20, 5'd10, 5'd10, 5'd11};
    vecs[3] = '{32'h0000_0013, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0};
    vecs[4] = '{32'hFE01_0113, 7'h13, 3'd0, 7'h7F, 5'd2,  5'd2,  5'd0};

    // Reset state
    apply_reset();
    chk("rst_req",   32'(imem_bus.IFImemReq), 32'd0);
    chk("rst_valid", 32'(IFInstValid), 32'd0);
    chk("rst_inst",  IFInst, 32'h0000_0013);
    chk("rst_err",   32'(IFErr), 32'd0);
    chk("rst_mis",   32'(IFMisaligned), 32'd0);
    chk("rst_pc",    IFPC, 32'h0);
    chk("rst_pc4",   IFPCPlus4, 32'h4);

    // Minimum latency: one IDLE cycle, then valid two cycles after REQ entry
    tick();
    chk("lat_req",  32'(imem_bus.IFImemReq), 32'd1);
    chk("lat_addr", imem_bus.IFImemAddr, 32'h0);
    imem_bus.IFImemGnt = 1'b1;
    tick();
    imem_bus.IFImemGnt = 1'b0;
    chk("lat_req_drop", 32'(imem_bus.IFImemReq), 32'd0);
    chk("lat_not_yet",  32'(IFInstValid), 32'd0);
    imem_bus.IFImemRValid = 1'b1;
    imem_bus.IFImemRData  = 32'h00A3_0333;
    tick();
    chk("lat_valid", 32'(IFInstValid), 32'd1);
    // Stray rvalid during VALID must not disturb the held instruction
    imem_bus.IFImemRData = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) tick();
    imem_bus.IFImemRValid = 1'b0;
    chk("hold_valid", 32'(IFInstValid), 32'd1);
    chk("hold_inst",  IFInst, 32'h00A3_0333);
    chk("hold_pc",    IFPC, 32'h0);

    // Decode table, sequential PC
    exp_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      advance(1'b0, 32'h0);
      exp_pc = exp_pc + 32'd4;
      chk("tbl_valid_drop", 32'(IFInstValid), 32'd0);
      fetch("tbl", exp_pc, vecs[i].word);
      chk("tbl_op",  32'(IFOpcode), 32'(vecs[i].op));
      chk("tbl_f3",  32'(IFFunct3), 32'(vecs[i].f3));
      chk("tbl_f7",  32'(IFFunct7), 32'(vecs[i].f7));
      chk("tbl_rd",  32'(IFRd),     32'(vecs[i].rd));
      chk("tbl_rs1", 32'(IFRs1),    32'(vecs[i].rs1));
      chk("tbl_rs2", 32'(IFRs2),    32'(vecs[i].rs2));
      chk("tbl_pc4", IFPCPlus4, exp_pc + 32'd4);
    end

    // Redirect clears target bit0
    advance(1'b1, 32'h0000_0101);
    chk("redir_req",  32'(imem_bus.IFImemReq), 32'd1);
    chk("redir_addr", imem_bus.IFImemAddr, 32'h0000_0100);
    fetch("redir", 32'h0000_0100, 32'h0000_0013);

    // PC+4 wrap at the top of the address space
    advance(1'b1, 32'hFFFF_FFFC);
    fetch("wrap_top", 32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap_pc4", IFPCPlus4, 32'h0);
    advance(1'b0, 32'h0);
    chk("wrap_addr", imem_bus.IFImemAddr, 32'h0);
    chk("wrap_req",  32'(imem_bus.IFImemReq), 32'd1);

    // Redirect to a target with bit1 set
    fetch("pre_mis", 32'h0, 32'h0000_0013);
    advance(1'b1, 32'h0000_0102);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(IFMisaligned), 32'd1);
    chk("mis_err",  32'(IFErr), 32'd1);
    chk("mis_pc",   IFPC, 32'h0000_0102);
    imem_bus.IFImemGnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mis_noreq", 32'(imem_bus.IFImemReq), 32'd0);
      tick();
    end
    imem_bus.IFImemGnt = 1'b0;
`else
    chk("mis_flag", 32'(IFMisaligned), 32'd0);
    chk("mis_req",  32'(imem_bus.IFImemReq), 32'd1);
    chk("mis_addr", imem_bus.IFImemAddr, 32'h0000_0102);
    fetch("mis_fetch", 32'h0000_0102, 32'h0000_0013);
    chk("mis_err", 32'(IFErr), 32'd0);
`endif

    // Timeout: 255 REQ cycles without grant
    apply_reset();
    tick();
    for (int i = 0; i < 254; i++) tick();
    chk("to_pre_req", 32'(imem_bus.IFImemReq), 32'd1);
    chk("to_pre_err", 32'(IFErr), 32'd0);
    tick();
    chk("to_err",   32'(IFErr), 32'd1);
    chk("to_req",   32'(imem_bus.IFImemReq), 32'd0);
    chk("to_valid", 32'(IFInstValid), 32'd0);
    imem_bus.IFImemGnt    = 1'b1;
    imem_bus.IFImemRValid = 1'b1;
    IFAdvance             = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    chk("to_sticky_err", 32'(IFErr), 32'd1);
    chk("to_sticky_req", 32'(imem_bus.IFImemReq), 32'd0);
    chk("to_frozen_pc",  IFPC, 32'h0);
    apply_reset();
    chk("to_cleared", 32'(IFErr), 32'd0);

    // Grant on the expiry cycle wins
    tick();
    for (int i = 0; i < 254; i++) tick();
    imem_bus.IFImemGnt = 1'b1;
    tick();
    imem_bus.IFImemGnt = 1'b0;
    chk("tie_err", 32'(IFErr), 32'd0);
    chk("tie_req", 32'(imem_bus.IFImemReq), 32'd0);
    imem_bus.IFImemRValid = 1'b1;
    imem_bus.IFImemRData  = 32'h1234_5678;
    tick();
    imem_bus.IFImemRValid = 1'b0;
    chk("tie_valid", 32'(IFInstValid), 32'd1);
    chk("tie_inst",  IFInst, 32'h1234_5678);
    chk("tie_err2",  32'(IFErr), 32'd0);

    // Reset while waiting for read data; late rvalid is ignored
    advance(1'b0, 32'h0);
    imem_bus.IFImemGnt = 1'b1;
    tick();
    imem_bus.IFImemGnt = 1'b0;
    IFRstN = 1'b0;
    tick();
    IFRstN = 1'b1;
    imem_bus.IFImemRValid = 1'b1;
    imem_bus.IFImemRData  = 32'hDEAD_BEEF;
    tick();
    chk("abort_req",   32'(imem_bus.IFImemReq), 32'd1);
    tick();
    imem_bus.IFImemRValid = 1'b0;
    chk("abort_valid", 32'(IFInstValid), 32'd0);
    chk("abort_inst",  IFInst, 32'h0000_0013);
    chk("abort_pc",    IFPC, 32'h0);
    fetch("abort_refetch", 32'h0, 32'h0000_0033);

    // Randomized run against a PC/memory reference model
    apply_reset();
    exp_pc    = 32'h0;
    granted   = 1'b0;
    wcnt      = 0;
    req_age   = 0;
    presented = 0;
    seen      = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_pc",  IFPC, exp_pc);
      chk("rnd_err", 32'(IFErr), 32'd0);
      if (imem_bus.IFImemReq) chk("rnd_addr", imem_bus.IFImemAddr, exp_pc);
      if (IFInstValid && !seen) begin
        presented++;
        seen = 1'b1;
        chk("rnd_inst", IFInst, memw(exp_pc));
        chk("rnd_rd",   32'(IFRd), 32'((memw(exp_pc) >> 7) & 32'h1F));
        chk("rnd_pc4",  IFPCPlus4, exp_pc + 32'd4);
      end
      idle_inputs();
      IFTarget = $urandom;
      if (granted) begin
        IFAdvance   = ($urandom_range(0, 1) == 1);
        IFNextPCSrc = 1'b1;
        if (wcnt == 0) begin
          imem_bus.IFImemRValid = 1'b1;
          imem_bus.IFImemRData  = memw(exp_pc);
          granted = 1'b0;
        end else begin
          wcnt--;
        end
      end else if (imem_bus.IFImemReq) begin
        imem_bus.IFImemGnt    = ($urandom_range(0, 1) == 1) || (req_age >= 6);
        imem_bus.IFImemRValid = ($urandom_range(0, 3) == 0);
        imem_bus.IFImemRData  = $urandom;
        req_age++;
        if (imem_bus.IFImemGnt) begin
          granted = 1'b1;
          wcnt    = $urandom_range(0, 2);
          req_age = 0;
        end
      end else if (IFInstValid) begin
        imem_bus.IFImemRValid = ($urandom_range(0, 3) == 0);
        imem_bus.IFImemRData  = $urandom;
        if ($urandom_range(0, 2) == 0) begin
          IFAdvance   = 1'b1;
          IFNextPCSrc = ($urandom_range(0, 1) == 1);
          IFTarget    = $urandom & ~32'h2;
          exp_pc      = IFNextPCSrc ? (IFTarget & ~32'h1) : exp_pc + 32'd4;
          seen        = 1'b0;
        end
      end else begin
        IFAdvance   = ($urandom_range(0, 1) == 1);
        IFNextPCSrc = 1'b1;
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (presented < 100) begin
      errors++;
      $display("FAIL rnd_progress: got %0d instructions expected at least 100", presented);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
